uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port rx_data, input, 8 bits, received byte from the upstream async receiver.
REQ-005 SHALL have port rx_data_ready, input, 1 bit, one-clk pulse marking rx_data valid.
REQ-006 SHALL have port rx_endofpacket, input, 1 bit, one-clk pulse marking a line-idle gap.
REQ-007 SHALL have port reg_addr, output, 8 bits, DDS register address of the last accepted frame.
REQ-008 SHALL have port reg_wdata, output, 32 bits, write data of the last accepted frame.
REQ-009 SHALL have port reg_we, output, 1 bit, one-clk write strobe.
REQ-010 SHALL have port frame_err, output, 1 bit, one-clk pulse when a frame is rejected.
REQ-011 SHALL have port err_count, output, 8 bits, count of rejected frames.
REQ-012 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 SHALL use this frame format: SYNC_BYTE, ADDR, D3, D2, D1, D0 (MSB first), CSUM, where CSUM = ADDR ^ D3 ^ D2 ^ D1 ^ D0.
REQ-014 SHALL implement states IDLE, ADDR, DATA and CSUM, with a 2-bit byte counter used in DATA.
REQ-015 SHALL move IDLE->ADDR on rx_data_ready with rx_data==SYNC_BYTE, and ignore any other byte in IDLE (no error).
REQ-016 SHALL, on rx_data_ready in ADDR, capture the byte into an address shadow, seed the running XOR with that byte, and go to DATA with the counter at 0.
REQ-017 SHALL, on each rx_data_ready in DATA, shift the byte into a 32-bit data shadow from the LSB side, XOR it into the running XOR, and increment the counter; it SHALL go to CSUM after the 4th byte.
REQ-018 SHALL, on rx_data_ready in CSUM, compare rx_data with the running XOR and return to IDLE.
- On match: reg_addr and reg_wdata update from the shadows, and reg_we pulses high for exactly one clk on the cycle after the CSUM byte's rx_data_ready.
- On mismatch: frame_err pulses on that same following cycle; reg_addr and reg_wdata are unchanged.
REQ-019 SHALL treat rx_endofpacket while the state is not IDLE as an abort: return to IDLE and pulse frame_err on the next cycle, with no write.
REQ-020 SHALL give rx_endofpacket priority when it coincides with rx_data_ready: the byte is dropped, and if the state was IDLE nothing happens.
REQ-021 SHALL ignore rx_endofpacket in IDLE.
REQ-022 SHALL treat a SYNC_BYTE value arriving mid-frame as ordinary data (no resynchronisation).
REQ-023 SHALL increment err_count on each frame_err pulse and saturate it at 8'hFF (no wrap).
REQ-024 SHALL hold reg_addr and reg_wdata stable between accepted frames.
REQ-025 SHALL never assert reg_we and frame_err in the same cycle.
REQ-026 SHALL accept back-to-back frames with zero idle cycles between a CSUM byte and the next SYNC_BYTE.

Reset
REQ-027 SHALL, while rst_n is low, force the state to IDLE, the counter to 0, and reg_addr, reg_wdata, the shadows, the running XOR and err_count to 0, with reg_we, frame_err and busy at 0.
REQ-028 SHALL treat rst_n asserted mid-frame as discarding the partial frame with no write and no frame_err.
REQ-029 SHALL process the first rx_data_ready after rst_n deasserts normally.

Verification
REQ-030 SHALL pass this scenario: bytes A5 12 01 02 03 04 16 -> one reg_we pulse, reg_addr=8'h12, reg_wdata=32'h01020304, err_count=0.
REQ-031 SHALL pass this scenario: bytes A5 12 01 02 03 04 17 -> frame_err pulse, no reg_we, err_count=1, reg_addr and reg_wdata keep their prior values.
REQ-032 SHALL pass this scenario: bytes A5 12 01, then rx_endofpacket -> frame_err pulse, busy falls, then a valid frame A5 34 00 00 00 FF CB -> reg_addr=8'h34, reg_wdata=32'h000000FF.
REQ-033 SHALL pass this scenario: leading junk bytes 00 FF 5A, then a valid frame -> exactly one reg_we and no frame_err.
REQ-034 SHALL pass this scenario: 300 consecutive bad-checksum frames -> err_count saturates at 8'hFF.
REQ-035 SHALL pass this scenario: rst_n pulsed low after A5 12 01 02 -> no reg_we, no frame_err, busy=0, and a following valid frame is accepted.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Turns a byte stream from an async receiver into DDS register writes.
// Frame layout: SYNC_BYTE, ADDR, D3, D2, D1, D0, CSUM.
// CSUM is the XOR of ADDR and the four data bytes.
//
// Ports
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   rx_data        : received byte
//   rx_data_ready  : one-clk strobe, rx_data valid (no backpressure)
//   rx_endofpacket : one-clk strobe, line went idle (aborts a partial frame)
//   reg_addr       : register address of the last accepted frame
//   reg_wdata      : write data of the last accepted frame
//   reg_we         : one-clk write strobe, cycle after a good CSUM byte
//   frame_err      : one-clk pulse when a frame is rejected
//   err_count      : saturating count of rejected frames
//   busy           : high while a frame is in progress
//
// Handshake: the receiver side is strobe-only. A byte is consumed on every
// rising edge where rx_data_ready is high, and this block never stalls it.
// rx_endofpacket wins over rx_data_ready in the same cycle.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    input  logic        rx_endofpacket,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_we,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [7:0]  addr_sh;
    logic [31:0] data_sh;
    logic [7:0]  csum_acc;

    // Saturating increment, used by both rejection paths.
    logic [7:0] err_count_inc;
    assign err_count_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            byte_cnt  <= 2'd0;
            addr_sh   <= 8'h00;
            data_sh   <= 32'h0;
            csum_acc  <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 32'h0;
            reg_we    <= 1'b0;
            frame_err <= 1'b0;
            err_count <= 8'h00;
        end else begin
            reg_we    <= 1'b0;
            frame_err <= 1'b0;

            if (rx_endofpacket) begin
                // Line idle mid-frame means the frame is truncated; any byte
                // arriving in the same cycle is dropped.
                if (state != ST_IDLE) begin
                    state     <= ST_IDLE;
                    frame_err <= 1'b1;
                    err_count <= err_count_inc;
                end
            end else if (rx_data_ready) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        addr_sh  <= rx_data;
                        csum_acc <= rx_data;
                        byte_cnt <= 2'd0;
                        state    <= ST_DATA;
                    end
                    ST_DATA: begin
                        // MSB first on the wire, so shift in from the bottom.
                        data_sh  <= {data_sh[23:0], rx_data};
                        csum_acc <= csum_acc ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (rx_data == csum_acc) begin
                            reg_addr  <= addr_sh;
                            reg_wdata <= data_sh;
                            reg_we    <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_count <= err_count_inc;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_ready;
    logic        rx_endofpacket;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    int tests_run = 0;
    int fails     = 0;

    // Pulse monitors, sampled on the falling edge.
    int we_pulses   = 0;
    int err_pulses  = 0;
    int both_pulses = 0;
    int we_base;
    int err_base;

    uart_cmd_parser #(.SYNC_BYTE(8'hA5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_endofpacket (rx_endofpacket),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_we         (reg_we),
        .frame_err      (frame_err),
        .err_count      (err_count),
        .busy           (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we) we_pulses++;
            if (frame_err) err_pulses++;
            if (reg_we && frame_err) both_pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks; all are entered and left on a falling edge.
    task automatic put(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
    endtask

    task automatic put_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs);
        put(8'hA5);
        put(a);
        put(d[31:24]);
        put(d[23:16]);
        put(d[15:8]);
        put(d[7:0]);
        put(cs);
    endtask

    task automatic eop(input logic with_byte, input logic [7:0] b);
        rx_data        = b;
        rx_data_ready  = with_byte;
        rx_endofpacket = 1'b1;
        @(negedge clk);
        rx_data_ready  = 1'b0;
        rx_endofpacket = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic mark();
        we_base  = we_pulses;
        err_base = err_pulses;
    endtask

    initial begin
        rst_n          = 1'b0;
        rx_data        = 8'h00;
        rx_data_ready  = 1'b0;
        rx_endofpacket = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_addr",  {24'h0, reg_addr}, 32'h0);
        check("rst_wdata", reg_wdata, 32'h0);
        check("rst_we",    {31'h0, reg_we}, 32'h0);
        check("rst_ferr",  {31'h0, frame_err}, 32'h0);
        check("rst_ecnt",  {24'h0, err_count}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame; first byte after reset is processed normally
        mark();
        put(8'hA5);
        check("busy_after_sync", {31'h0, busy}, 32'h1);
        put(8'h12); put(8'h01); put(8'h02); put(8'h03); put(8'h04); put(8'h16);
        settle();
        check("good_we",    we_pulses - we_base, 1);
        check("good_err",   err_pulses - err_base, 0);
        check("good_addr",  {24'h0, reg_addr}, 32'h12);
        check("good_wdata", reg_wdata, 32'h01020304);
        check("good_ecnt",  {24'h0, err_count}, 32'h0);
        check("good_busy",  {31'h0, busy}, 32'h0);

        // Bad checksum
        mark();
        put_frame(8'h12, 32'h01020304, 8'h17);
        settle();
        check("badcs_we",    we_pulses - we_base, 0);
        check("badcs_err",   err_pulses - err_base, 1);
        check("badcs_ecnt",  {24'h0, err_count}, 32'h1);
        check("badcs_addr",  {24'h0, reg_addr}, 32'h12);
        check("badcs_wdata", reg_wdata, 32'h01020304);

        // Abort by end-of-packet, then recover
        mark();
        put(8'hA5); put(8'h12); put(8'h01);
        eop(1'b0, 8'h00);
        settle();
        check("abort_err",  err_pulses - err_base, 1);
        check("abort_we",   we_pulses - we_base, 0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ecnt", {24'h0, err_count}, 32'h2);
        mark();
        put_frame(8'h34, 32'h000000FF, 8'hCB);
        settle();
        check("recov_we",    we_pulses - we_base, 1);
        check("recov_addr",  {24'h0, reg_addr}, 32'h34);
        check("recov_wdata", reg_wdata, 32'h000000FF);

        // Leading junk ignored
        mark();
        put(8'h00); put(8'hFF); put(8'h5A);
        check("junk_busy", {31'h0, busy}, 32'h0);
        put_frame(8'h56, 32'h11223344, 8'h12);
        settle();
        check("junk_we",    we_pulses - we_base, 1);
        check("junk_err",   err_pulses - err_base, 0);
        check("junk_wdata", reg_wdata, 32'h11223344);

        // Sync value mid-frame is plain data
        mark();
        put_frame(8'hA5, 32'hA5A5A5A5, 8'hA5);
        settle();
        check("syncdata_we",    we_pulses - we_base, 1);
        check("syncdata_addr",  {24'h0, reg_addr}, 32'hA5);
        check("syncdata_wdata", reg_wdata, 32'hA5A5A5A5);

        // EOP with a sync byte in IDLE: byte dropped, no error
        mark();
        eop(1'b1, 8'hA5);
        check("eop_idle_busy", {31'h0, busy}, 32'h0);
        settle();
        check("eop_idle_err", err_pulses - err_base, 0);

        // EOP coincident with a data byte mid-frame: abort, byte dropped
        mark();
        put(8'hA5); put(8'h12);
        eop(1'b1, 8'h01);
        check("eop_data_busy", {31'h0, busy}, 32'h0);
        settle();
        check("eop_data_err", err_pulses - err_base, 1);
        check("eop_data_we",  we_pulses - we_base, 0);
        check("eop_data_ecnt", {24'h0, err_count}, 32'h3);

        // Back-to-back frames, no gap between CSUM and next sync
        mark();
        put_frame(8'h12, 32'h01020304, 8'h16);
        put_frame(8'h34, 32'h000000FF, 8'hCB);
        settle();
        check("b2b_we",   we_pulses - we_base, 2);
        check("b2b_addr", {24'h0, reg_addr}, 32'h34);

        // Saturation of the error counter
        mark();
        for (int i = 0; i < 300; i++) put_frame(8'h12, 32'h01020304, 8'h17);
        settle();
        check("sat_pulses", err_pulses - err_base, 300);
        check("sat_ecnt",   {24'h0, err_count}, 32'hFF);
        check("sat_wdata",  reg_wdata, 32'h000000FF);

        // Reset mid-frame
        mark();
        put(8'hA5); put(8'h12); put(8'h01); put(8'h02);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_ecnt", {24'h0, err_count}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_we",  we_pulses - we_base, 0);
        check("midrst_err", err_pulses - err_base, 0);
        mark();
        put_frame(8'h12, 32'h01020304, 8'h16);
        settle();
        check("postrst_we",   we_pulses - we_base, 1);
        check("postrst_addr", {24'h0, reg_addr}, 32'h12);

        check("we_err_overlap", both_pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
